// File: rtl/pixel_stream_capture.sv
// Camera capture stage: oversamples a DVP bus in clk_i, packs 1-4 beats per pixel
// and streams the words out through a small FIFO tagged with sof/eol flags.
module pixel_stream_capture #(
    parameter int DATA_WIDTH        = 8,
    parameter int BYTES_PER_PIXEL   = 2,
    parameter bit MSB_FIRST         = 1'b1,
    parameter bit VSYNC_ACTIVE_HIGH = 1'b1,
    parameter int FIFO_DEPTH        = 4,
    parameter int CNT_WIDTH         = 12
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  enable_i,
    input  logic                                  cam_pclk_i,
    input  logic [DATA_WIDTH-1:0]                 cam_data_i,
    input  logic                                  cam_href_i,
    input  logic                                  cam_vsync_i,
    output logic                                  m_valid_o,
    input  logic                                  m_ready_i,
    output logic [DATA_WIDTH*BYTES_PER_PIXEL-1:0] m_data_o,
    output logic                                  m_sof_o,
    output logic                                  m_eol_o,
    output logic                                  frame_done_o,
    output logic [CNT_WIDTH-1:0]                  line_count_o,
    output logic [CNT_WIDTH-1:0]                  last_width_o,
    output logic                                  overflow_o,
    output logic                                  partial_err_o,
    input  logic                                  clear_err_i
);
    // state  | meaning
    // IDLE   | disarmed; waits for enable_i while in vertical blanking
    // VBLANK | inside blanking; waits for the frame to start
    // ACTIVE | capturing beats and pushing pixel words
    // DROP   | FIFO overflowed; discarding beats until the frame ends
    typedef enum logic [1:0] {ST_IDLE, ST_VBLANK, ST_ACTIVE, ST_DROP} state_t;

    localparam int PW = DATA_WIDTH * BYTES_PER_PIXEL;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] LAST_BEAT = 2'(BYTES_PER_PIXEL - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    // Idle level of the pin, so reset never looks like a blanking edge.
    localparam logic VS_IDLE = ~VSYNC_ACTIVE_HIGH;

    state_t r_state;
    state_t w_state_next;

    logic                  r_pclk_s1, r_pclk_s2;
    logic                  r_href_s1, r_href_s2, r_href_q;
    logic                  r_vsync_s1, r_vsync_s2, r_vs_act_q;
    logic [DATA_WIDTH-1:0] r_data_s1;

    logic w_pclk_rise, w_href_fall, w_vs_act, w_vs_rise, w_vs_fall;

    logic [PW-1:0]        r_asm;
    logic [PW-1:0]        w_asm_next;
    logic [1:0]           r_beat_cnt;
    logic [PW-1:0]        r_pend_data;
    logic                 r_pend_vld;
    logic                 r_sof_pend;
    logic [CNT_WIDTH-1:0] r_line_cnt;
    logic [CNT_WIDTH-1:0] r_width_cnt;
    logic [CNT_WIDTH-1:0] w_line_cnt_upd;

    logic w_beat_take, w_word_done, w_push, w_push_eol, w_push_ok;
    logic w_line_end, w_frame_start, w_frame_end, w_overflow;

    logic [PW-1:0] r_mem_data [FIFO_DEPTH];
    logic          r_mem_sof  [FIFO_DEPTH];
    logic          r_mem_eol  [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_full, w_pop, w_can_push;

    logic                 r_frame_done;
    logic [CNT_WIDTH-1:0] r_line_count;
    logic [CNT_WIDTH-1:0] r_last_width;
    logic                 r_overflow;
    logic                 r_partial_err;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_pclk_s1  <= 1'b0;
            r_pclk_s2  <= 1'b0;
            r_href_s1  <= 1'b0;
            r_href_s2  <= 1'b0;
            r_href_q   <= 1'b0;
            r_vsync_s1 <= VS_IDLE;
            r_vsync_s2 <= VS_IDLE;
            r_vs_act_q <= 1'b0;
            r_data_s1  <= '0;
        end else begin
            r_pclk_s1  <= cam_pclk_i;
            r_pclk_s2  <= r_pclk_s1;
            r_href_s1  <= cam_href_i;
            r_href_s2  <= r_href_s1;
            r_href_q   <= r_href_s2;
            r_vsync_s1 <= cam_vsync_i;
            r_vsync_s2 <= r_vsync_s1;
            r_vs_act_q <= w_vs_act;
            r_data_s1  <= cam_data_i;
        end
    end

    assign w_pclk_rise = r_pclk_s1 & ~r_pclk_s2;
    assign w_href_fall = ~r_href_s2 & r_href_q;
    assign w_vs_act    = r_vsync_s2 ~^ VSYNC_ACTIVE_HIGH;
    assign w_vs_rise   = w_vs_act & ~r_vs_act_q;
    assign w_vs_fall   = ~w_vs_act & r_vs_act_q;

    generate
        if (BYTES_PER_PIXEL == 1) begin : g_asm_one
            assign w_asm_next = r_data_s1;
        end else if (MSB_FIRST) begin : g_asm_msb
            assign w_asm_next = {r_asm[PW-DATA_WIDTH-1:0], r_data_s1};
        end else begin : g_asm_lsb
            assign w_asm_next = {r_data_s1, r_asm[PW-1:DATA_WIDTH]};
        end
    endgenerate

    assign w_full     = (r_count == FULL_CNT);
    assign w_pop      = m_valid_o & m_ready_i;
    assign w_can_push = ~w_full | w_pop;
    assign w_push_ok  = w_push & w_can_push;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_beat_take   = 1'b0;
        w_word_done   = 1'b0;
        w_push        = 1'b0;
        w_push_eol    = 1'b0;
        w_line_end    = 1'b0;
        w_frame_start = 1'b0;
        w_frame_end   = 1'b0;
        w_overflow    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (enable_i && w_vs_act) begin
                    w_state_next = ST_VBLANK;
                end
            end
            ST_VBLANK: begin
                if (w_vs_fall) begin
                    w_frame_start = 1'b1;
                    w_state_next  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (w_pclk_rise && r_href_s2) begin
                    w_beat_take = 1'b1;
                    if (r_beat_cnt == LAST_BEAT) begin
                        w_word_done = 1'b1;
                        w_push      = r_pend_vld;
                    end
                end
                if (w_href_fall) begin
                    w_line_end = 1'b1;
                    w_push     = r_pend_vld;
                    w_push_eol = 1'b1;
                end
                if (w_push && !w_can_push) begin
                    w_overflow   = 1'b1;
                    w_state_next = ST_DROP;
                end
                if (w_vs_rise) begin
                    w_frame_end  = 1'b1;
                    w_state_next = enable_i ? ST_VBLANK : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (w_vs_rise) begin
                    w_frame_end  = 1'b1;
                    w_state_next = enable_i ? ST_VBLANK : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Empty lines leave the line count untouched.
    assign w_line_cnt_upd = (w_line_end && r_pend_vld && r_line_cnt != CNT_MAX)
                            ? r_line_cnt + 1'b1 : r_line_cnt;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_asm         <= '0;
            r_beat_cnt    <= '0;
            r_pend_data   <= '0;
            r_pend_vld    <= 1'b0;
            r_sof_pend    <= 1'b0;
            r_line_cnt    <= '0;
            r_width_cnt   <= '0;
            r_frame_done  <= 1'b0;
            r_line_count  <= '0;
            r_last_width  <= '0;
            r_overflow    <= 1'b0;
            r_partial_err <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            r_line_cnt   <= w_line_cnt_upd;
            if (w_beat_take) begin
                r_asm      <= w_asm_next;
                r_beat_cnt <= w_word_done ? 2'd0 : r_beat_cnt + 2'd1;
            end
            if (w_word_done) begin
                r_pend_data <= w_asm_next;
                r_pend_vld  <= 1'b1;
                if (r_width_cnt != CNT_MAX) begin
                    r_width_cnt <= r_width_cnt + 1'b1;
                end
            end
            if (w_push_ok) begin
                r_sof_pend <= 1'b0;
            end
            if (w_line_end) begin
                r_pend_vld  <= 1'b0;
                r_beat_cnt  <= '0;
                r_width_cnt <= '0;
                if (r_pend_vld) begin
                    r_last_width <= r_width_cnt;
                end
            end
            if (w_overflow) begin
                r_pend_vld <= 1'b0;
            end
            if (w_frame_end) begin
                r_line_count <= w_line_cnt_upd;
            end
            if (w_frame_start) begin
                r_sof_pend  <= 1'b1;
                r_pend_vld  <= 1'b0;
                r_beat_cnt  <= '0;
                r_line_cnt  <= '0;
                r_width_cnt <= '0;
            end
            if (w_overflow) begin
                r_overflow <= 1'b1;
            end else if (clear_err_i) begin
                r_overflow <= 1'b0;
            end
            if (w_line_end && r_beat_cnt != 2'd0) begin
                r_partial_err <= 1'b1;
            end else if (clear_err_i) begin
                r_partial_err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_sof[i]  <= 1'b0;
                r_mem_eol[i]  <= 1'b0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem_data[r_wr_ptr] <= r_pend_data;
                r_mem_sof[r_wr_ptr]  <= r_sof_pend;
                r_mem_eol[r_wr_ptr]  <= w_push_eol;
                r_wr_ptr             <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign m_valid_o     = (r_count != '0);
    assign m_data_o      = r_mem_data[r_rd_ptr];
    assign m_sof_o       = r_mem_sof[r_rd_ptr];
    assign m_eol_o       = r_mem_eol[r_rd_ptr];
    assign frame_done_o  = r_frame_done;
    assign line_count_o  = r_line_count;
    assign last_width_o  = r_last_width;
    assign overflow_o    = r_overflow;
    assign partial_err_o = r_partial_err;

endmodule

// File: tb/tb_pixel_stream_capture.sv
// Bench for pixel_stream_capture: a 2-beat MSB-first instance and a 3-beat
// LSB-first instance share the camera pins; HREF is steered to one at a time.
module tb_pixel_stream_capture;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, cam_pclk, cam_href, cam_vsync, m_ready, clear_err, sel3;
    logic [7:0] cam_data;
    logic       w_href0, w_href3;
    assign w_href0 = cam_href & ~sel3;
    assign w_href3 = cam_href & sel3;

    logic        m_valid0, m_sof0, m_eol0, fd0, ovf0, perr0;
    logic [15:0] m_data0;
    logic [11:0] lc0, lw0;
    logic        m_valid3, m_sof3, m_eol3, fd3, ovf3, perr3;
    logic [23:0] m_data3;
    logic [11:0] lc3, lw3;

    int checks = 0;
    int errors = 0;
    int fd0_cnt = 0;
    logic [17:0] q0[$];
    logic [25:0] q3[$];

    pixel_stream_capture #(.DATA_WIDTH(8), .BYTES_PER_PIXEL(2), .MSB_FIRST(1'b1),
        .VSYNC_ACTIVE_HIGH(1'b1), .FIFO_DEPTH(4), .CNT_WIDTH(12)) dut (
        .clk_i(clk), .reset_i(rst), .enable_i(enable), .cam_pclk_i(cam_pclk),
        .cam_data_i(cam_data), .cam_href_i(w_href0), .cam_vsync_i(cam_vsync),
        .m_valid_o(m_valid0), .m_ready_i(m_ready), .m_data_o(m_data0),
        .m_sof_o(m_sof0), .m_eol_o(m_eol0), .frame_done_o(fd0),
        .line_count_o(lc0), .last_width_o(lw0), .overflow_o(ovf0),
        .partial_err_o(perr0), .clear_err_i(clear_err));

    pixel_stream_capture #(.DATA_WIDTH(8), .BYTES_PER_PIXEL(3), .MSB_FIRST(1'b0),
        .VSYNC_ACTIVE_HIGH(1'b1), .FIFO_DEPTH(4), .CNT_WIDTH(12)) dut3 (
        .clk_i(clk), .reset_i(rst), .enable_i(enable), .cam_pclk_i(cam_pclk),
        .cam_data_i(cam_data), .cam_href_i(w_href3), .cam_vsync_i(cam_vsync),
        .m_valid_o(m_valid3), .m_ready_i(m_ready), .m_data_o(m_data3),
        .m_sof_o(m_sof3), .m_eol_o(m_eol3), .frame_done_o(fd3),
        .line_count_o(lc3), .last_width_o(lw3), .overflow_o(ovf3),
        .partial_err_o(perr3), .clear_err_i(clear_err));

    // Scoreboard pop on every accepted word of either instance.
    always @(negedge clk) begin
        logic [17:0] e0;
        logic [25:0] e3;
        if (!rst) begin
            if (fd0) fd0_cnt++;
            if (m_valid0 && m_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    errors++;
                    $display("FAIL word0_unexpected got data=%h sof=%b eol=%b, none expected",
                             m_data0, m_sof0, m_eol0);
                end else begin
                    e0 = q0.pop_front();
                    if ({m_data0, m_sof0, m_eol0} !== e0) begin
                        errors++;
                        $display("FAIL word0 got data=%h sof=%b eol=%b exp data=%h sof=%b eol=%b",
                                 m_data0, m_sof0, m_eol0, e0[17:2], e0[1], e0[0]);
                    end
                end
            end
            if (m_valid3 && m_ready) begin
                checks++;
                if (q3.size() == 0) begin
                    errors++;
                    $display("FAIL word3_unexpected got data=%h sof=%b eol=%b, none expected",
                             m_data3, m_sof3, m_eol3);
                end else begin
                    e3 = q3.pop_front();
                    if ({m_data3, m_sof3, m_eol3} !== e3) begin
                        errors++;
                        $display("FAIL word3 got data=%h sof=%b eol=%b exp data=%h sof=%b eol=%b",
                                 m_data3, m_sof3, m_eol3, e3[25:2], e3[1], e3[0]);
                    end
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic pclk_beat(input logic [7:0] d);
        cam_data = d;
        repeat (4) @(negedge clk);
        cam_pclk = 1'b1;
        repeat (4) @(negedge clk);
        cam_pclk = 1'b0;
    endtask

    task automatic drive_frame(input int lines, input int beats, input logic [7:0] base);
        logic [7:0] b;
        b = base;
        cam_vsync = 1'b1;
        repeat (12) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (12) @(negedge clk);
        for (int l = 0; l < lines; l++) begin
            cam_href = 1'b1;
            repeat (6) @(negedge clk);
            for (int k = 0; k < beats; k++) begin
                pclk_beat(b);
                b = b + 8'h11;
            end
            repeat (4) @(negedge clk);
            cam_href = 1'b0;
            repeat (12) @(negedge clk);
        end
        cam_vsync = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    // Reference model for the 2-beat MSB-first instance.
    task automatic expect_frame0(input int lines, input int beats, input logic [7:0] base,
                                 input int max_words);
        logic [7:0] b, hi;
        int n, npix;
        b = base;
        n = 0;
        npix = beats / 2;
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < npix; p++) begin
                hi = b;
                b = b + 8'h11;
                if (n < max_words) q0.push_back({hi, b, (n == 0), (p == npix - 1)});
                b = b + 8'h11;
                n++;
            end
            if (beats % 2 != 0) b = b + 8'h11;
        end
    endtask

    task automatic wait_drain0(input string name);
        int n;
        n = 0;
        while (q0.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d words outstanding, need 0", name, q0.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_valid0, m_sof0, m_eol0, fd0, ovf0, perr0} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b need 000000", {m_valid0, m_sof0, m_eol0, fd0, ovf0, perr0});
        end
        checks++;
        if (m_data0 !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got %h need 0000", m_data0);
        end
        checks++;
        if (lc0 !== 12'd0 || lw0 !== 12'd0) begin
            errors++;
            $display("FAIL reset_counts got lc=%0d lw=%0d need 0 0", lc0, lw0);
        end
        checks++;
        if (m_valid3 !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid3 got %b need 0", m_valid3);
        end
    endtask

    task automatic test_basic();
        int f0;
        f0 = fd0_cnt;
        m_ready = 1'b1;
        expect_frame0(2, 6, 8'hA1, 100);
        drive_frame(2, 6, 8'hA1);
        wait_drain0("basic");
        checks++;
        if (fd0_cnt - f0 != 1) begin
            errors++;
            $display("FAIL basic_frame_done got %0d pulses need 1", fd0_cnt - f0);
        end
        checks++;
        if (lc0 !== 12'd2) begin
            errors++;
            $display("FAIL basic_line_count got %0d need 2", lc0);
        end
        checks++;
        if (lw0 !== 12'd3) begin
            errors++;
            $display("FAIL basic_last_width got %0d need 3", lw0);
        end
        checks++;
        if (perr0 !== 1'b0 || ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL basic_errs got perr=%b ovf=%b need 0 0", perr0, ovf0);
        end
    endtask

    task automatic test_bpp3();
        int n;
        q3.push_back({24'h332211, 1'b1, 1'b0});
        q3.push_back({24'h665544, 1'b0, 1'b1});
        sel3 = 1'b1;
        drive_frame(1, 6, 8'h11);
        sel3 = 1'b0;
        n = 0;
        while (q3.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q3.size() != 0) begin
            errors++;
            $display("FAIL bpp3_drain got %0d words outstanding, need 0", q3.size());
        end
        checks++;
        if (lc3 !== 12'd1 || lw3 !== 12'd2) begin
            errors++;
            $display("FAIL bpp3_counts got lc=%0d lw=%0d need 1 2", lc3, lw3);
        end
    endtask

    task automatic test_partial();
        expect_frame0(1, 5, 8'h05, 100);
        drive_frame(1, 5, 8'h05);
        wait_drain0("partial");
        checks++;
        if (perr0 !== 1'b1) begin
            errors++;
            $display("FAIL partial_flag got %b need 1", perr0);
        end
        checks++;
        if (lw0 !== 12'd2 || lc0 !== 12'd1) begin
            errors++;
            $display("FAIL partial_counts got lw=%0d lc=%0d need 2 1", lw0, lc0);
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
        checks++;
        if (perr0 !== 1'b0) begin
            errors++;
            $display("FAIL partial_clear got %b need 0", perr0);
        end
    endtask

    task automatic test_overflow();
        int f0;
        logic [15:0] hold;
        f0 = fd0_cnt;
        m_ready = 1'b0;
        expect_frame0(1, 16, 8'h30, 4);
        drive_frame(1, 16, 8'h30);
        hold = m_data0;
        checks++;
        if (m_valid0 !== 1'b1 || m_sof0 !== 1'b1 || m_data0 !== q0[0][17:2]) begin
            errors++;
            $display("FAIL ovf_head got v=%b sof=%b data=%h need 1 1 %h",
                     m_valid0, m_sof0, m_data0, q0[0][17:2]);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (m_valid0 !== 1'b1 || m_data0 !== hold) begin
            errors++;
            $display("FAIL ovf_hold got v=%b data=%h need 1 %h", m_valid0, m_data0, hold);
        end
        checks++;
        if (ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag got %b need 1", ovf0);
        end
        checks++;
        if (fd0_cnt - f0 != 1) begin
            errors++;
            $display("FAIL ovf_frame_done got %0d pulses need 1", fd0_cnt - f0);
        end
        m_ready = 1'b1;
        wait_drain0("ovf");
        checks++;
        if (m_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty got valid=%b need 0", m_valid0);
        end
        expect_frame0(1, 4, 8'h40, 100);
        drive_frame(1, 4, 8'h40);
        wait_drain0("ovf_next");
        checks++;
        if (ovf0 !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky got %b need 1", ovf0);
        end
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        @(negedge clk);
        checks++;
        if (ovf0 !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear got %b need 0", ovf0);
        end
    endtask

    task automatic test_reset_midline();
        int f0;
        logic [7:0] b;
        m_ready = 1'b1;
        cam_vsync = 1'b1;
        repeat (12) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (12) @(negedge clk);
        cam_href = 1'b1;
        repeat (6) @(negedge clk);
        b = 8'h70;
        for (int k = 0; k < 3; k++) begin
            pclk_beat(b);
            b = b + 8'h11;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        f0 = fd0_cnt;
        for (int k = 0; k < 3; k++) begin
            pclk_beat(b);
            b = b + 8'h11;
        end
        repeat (4) @(negedge clk);
        cam_href = 1'b0;
        repeat (12) @(negedge clk);
        cam_href = 1'b1;
        repeat (6) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            pclk_beat(b);
            b = b + 8'h11;
        end
        repeat (4) @(negedge clk);
        cam_href = 1'b0;
        repeat (12) @(negedge clk);
        cam_vsync = 1'b1;
        repeat (12) @(negedge clk);
        checks++;
        if (m_valid0 !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_valid got %b need 0", m_valid0);
        end
        checks++;
        if (fd0_cnt != f0) begin
            errors++;
            $display("FAIL rstmid_frame_done got %0d pulses need 0", fd0_cnt - f0);
        end
        expect_frame0(1, 4, 8'h90, 100);
        drive_frame(1, 4, 8'h90);
        wait_drain0("rstmid");
        checks++;
        if (lc0 !== 12'd1) begin
            errors++;
            $display("FAIL rstmid_line_count got %0d need 1", lc0);
        end
    endtask

    initial begin
        rst = 1'b1;
        enable = 1'b1;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        cam_vsync = 1'b0;
        cam_data = 8'h00;
        m_ready = 1'b1;
        clear_err = 1'b0;
        sel3 = 1'b0;
        test_reset();
        test_basic();
        test_bpp3();
        test_partial();
        test_overflow();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
